alu_nibble_sequencer: RTL and testbench

//  Multi-cycle controller that drives one shared combinational 4-bit ALU slice
//  (a, b, op, cin -> result, cout) to perform WIDTH-bit AND/OR/ADD/SUB/SLT.

---
 rtl/alu_nibble_sequencer.sv | 91 +++++++++
 tb/tb_alu_nibble_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: sequences WIDTH-bit AND/OR/ADD/SUB/SLT through a shared 4-bit ALU slice,
// one nibble per cycle LSB first, with valid/ready request and response handshakes.
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_illegal,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic [3:0]       alu_result,
    input  logic             alu_cout
);
    localparam int NIB = WIDTH / 4;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0] op_q;
    logic [IW-1:0] idx;
    logic [IW+1:0] base;
    logic carry, legal, less, run;
    assign base = {idx, 2'b00};
    assign run = state == RUN;
    assign legal = req_op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    assign req_ready = state == IDLE;
    assign alu_a = run ? a_q[base +: 4] : '0;
    assign alu_b = run ? b_q[base +: 4] : '0;
    assign alu_op = !run ? 3'b000 : (op_q == 3'b111) ? 3'b110 : op_q;
    assign alu_cin = run & carry;
    // signs differ: a is less exactly when negative; otherwise the sign of a-b decides
    assign less = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1] : alu_result[3];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            rsp_result  <= '0;
            rsp_cout    <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    a_q         <= req_a;
                    b_q         <= req_b;
                    op_q        <= req_op;
                    idx         <= '0;
                    carry       <= (req_op == 3'b010) ? req_cin : req_op[2];
                    rsp_result  <= '0;
                    rsp_cout    <= 1'b0;
                    rsp_illegal <= !legal;
                    rsp_valid   <= !legal;
                    state       <= legal ? RUN : DONE;
                end
                RUN: begin
                    rsp_result[base +: 4] <= alu_result;
                    carry <= alu_cout & op_q[1];
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_cout  <= (op_q == 3'b111) ? 1'b0 : alu_cout & op_q[1];
                        if (op_q == 3'b111) rsp_result <= WIDTH'(less);
                    end
                end
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: directed bench with a behavioural 4-bit ALU slice attached to the sequencer.
module tb_alu_nibble_sequencer;
    localparam int WIDTH = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, req_cin = 1'b0;
    logic [2:0] req_op = '0;
    logic [WIDTH-1:0] req_a = '0, req_b = '0, rsp_result;
    logic rsp_valid, rsp_ready = 1'b0, rsp_cout, rsp_illegal;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic alu_cin, alu_cout;
    logic [4:0] sum;
    int errors = 0;
    int checks = 0;

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_illegal(rsp_illegal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    always_comb begin
        sum = {1'b0, alu_a} + {1'b0, alu_op[2] ? ~alu_b : alu_b} + {4'b0, alu_cin};
        alu_result = (alu_op == 3'b000) ? (alu_a & alu_b) : (alu_op == 3'b001) ? (alu_a | alu_b) : sum[3:0];
        alu_cout = alu_op[1] & sum[4];
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
        check("ready_before_accept", 16'(req_ready), 16'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic await_rsp(input int lat);
        int n = 0;
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1 n++;
            if (rsp_valid) got = 1;
        end
        check("latency", 16'(n), 16'(lat));
    endtask

    task automatic expect_rsp(input logic [WIDTH-1:0] res, input logic cout, input logic ill);
        check("result", rsp_result, res);
        check("cout", 16'(rsp_cout), 16'(cout));
        check("illegal", 16'(rsp_illegal), 16'(ill));
        check("ready_in_done", 16'(req_ready), 16'd0);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("valid_after_ack", 16'(rsp_valid), 16'd0);
        check("ready_after_ack", 16'(req_ready), 16'd1);
    endtask

    task automatic op_case(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic [WIDTH-1:0] res, input logic cout);
        send(op, a, b, cin);
        await_rsp(4);
        expect_rsp(res, cout, 1'b0);
        ack();
    endtask

    initial begin
        #2;
        check("rst_req_ready", 16'(req_ready), 16'd1);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_result", rsp_result, 16'h0000);
        check("rst_alu", {5'b0, alu_a, alu_b, alu_op}, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        op_case(3'b010, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        op_case(3'b010, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        op_case(3'b010, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
        op_case(3'b110, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        op_case(3'b110, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
        op_case(3'b000, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0);
        op_case(3'b001, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0);

        send(3'b111, 16'h8000, 16'h0001, 1'b0);
        check("slt_alu_op", 16'(alu_op), 16'h0006);
        check("slt_alu_cin", 16'(alu_cin), 16'h0001);
        check("slt_alu_b", 16'(alu_b), 16'h0001);
        await_rsp(4);
        expect_rsp(16'h0001, 1'b0, 1'b0);
        ack();
        op_case(3'b111, 16'h0001, 16'h8000, 1'b0, 16'h0000, 1'b0);
        op_case(3'b111, 16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 1'b0);
        op_case(3'b111, 16'h0003, 16'h0005, 1'b0, 16'h0001, 1'b0);

        send(3'b010, 16'h1234, 16'h1111, 1'b0);
        await_rsp(4);
        req_op = 3'b001; req_a = 16'h0F0F; req_b = 16'h00F0; req_cin = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 check("stall_result", rsp_result, 16'h2345);
            check("stall_valid", 16'(rsp_valid), 16'd1);
            check("stall_ready", 16'(req_ready), 16'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("hs_not_accepted", 16'(req_ready), 16'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("second_accepted", 16'(req_ready), 16'd0);
        await_rsp(4);
        expect_rsp(16'h0FFF, 1'b0, 1'b0);
        ack();

        send(3'b010, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("midrst_valid", 16'(rsp_valid), 16'd0);
        check("midrst_ready", 16'(req_ready), 16'd1);
        check("midrst_result", rsp_result, 16'h0000);
        check("midrst_alu_a", 16'(alu_a), 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 check("no_rsp_after_rst", 16'(rsp_valid), 16'd0);
        end
        op_case(3'b010, 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);

        send(3'b011, 16'h1234, 16'h5678, 1'b1);
        check("illegal_latency", 16'(rsp_valid), 16'd1);
        expect_rsp(16'h0000, 1'b0, 1'b1);
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
